sm4_result_writer: RTL and testbench

Downstream stage of the three-lane SM4 engine. It captures each 384-bit round result (three 128-bit groups) when the engine raises one_round_ok. It serialises the valid groups into 32-bit words with word addresses on a valid/ready stream toward the frame/DDR writer. It then returns a one-cycle out_ok so the engine advances group_num by 3.

---
 rtl/sm4_result_pkg.sv | 27 ++
 rtl/sm4_result_writer_if.sv | 24 ++
 rtl/sm4_result_word_sel.sv | 34 +++
 rtl/sm4_result_writer.sv | 163 ++++++++++++++++
 tb/tb_sm4_result_writer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sm4_result_pkg.sv
// Shared types and constants for the SM4 result writer: FSM encoding, word geometry, byte swap helper.
// The byte swap helper is only applied when SM4_RESULT_BSWAP_EN is defined.
package sm4_result_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_ACK      = 3'd3;
    localparam logic [2:0] ST_WAIT_LOW = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LOAD     = ST_LOAD,
        S_SEND     = ST_SEND,
        S_ACK      = ST_ACK,
        S_WAIT_LOW = ST_WAIT_LOW
    } sm4_state_e;

    localparam int WORDS_PER_GROUP = 4;
    localparam int MAX_WORDS       = 12;
    localparam int RESULT_W        = 384;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sm4_result_writer_if.sv
// Word stream from the SM4 result writer toward the frame/DDR writer.
interface sm4_result_writer_if;
    logic [31:0] m_data;
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    modport master (
        output m_data,
        output m_addr,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_addr,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sm4_result_word_sel.sv
// Picks 32-bit word k (most-significant word of each group first) out of the captured round result.
// With SM4_RESULT_BSWAP_EN defined the word is byte-swapped for a little-endian sink.
module sm4_result_word_sel
    import sm4_result_pkg::*;
(
    input  logic [RESULT_W-1:0] result_i,
    input  logic [3:0]          k_i,
    output logic [31:0]         word_o
);

    logic [3:0]  j_s;
    logic [31:0] raw_s;

    // Word k = 4g+w lives at bus word 4g+(3-w), i.e. the low two index bits inverted.
    always_comb begin
        j_s   = {k_i[3:2], ~k_i[1:0]};
        raw_s = 32'd0;
        if (k_i < 4'(MAX_WORDS)) begin
            raw_s = result_i[{j_s, 5'd0} +: 32];
        end else begin
            raw_s = 32'd0;
        end
    end

    // Optional little-endian presentation of the selected word.
    always_comb begin
`ifdef SM4_RESULT_BSWAP_EN
        word_o = bswap32(raw_s);
`else
        word_o = raw_s;
`endif
    end

endmodule

// File: rtl/sm4_result_writer.sv
// Captures a 3-group SM4 round result, streams its valid groups as addressed 32-bit words, then acks the engine.
// Optional SM4_RESULT_BSWAP_EN byte-swaps every emitted word (see sm4_result_word_sel).
module sm4_result_writer
    import sm4_result_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          GROUPS_PER_ROUND = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      h_sm4_start,
    input  logic                      one_round_ok,
    input  logic [RESULT_W-1:0]       sm4_dout,
    input  logic [31:0]               end_group_num,
    input  logic [31:0]               all_group_num,
    output logic                      out_ok,
    sm4_result_writer_if.master       m_if,
    output logic                      all_done
);

    sm4_state_e          state_q, state_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [31:0]         end_q, end_d;
    logic [31:0]         all_q, all_d;
    logic [3:0]          nwords_q, nwords_d;
    logic [3:0]          k_q, k_d;
    logic                all_done_q, all_done_d;

    logic [31:0]         rem_s;
    logic [3:0]          nwords_s;
    logic                final_round_s;
    logic                send_s;
    logic                last_s;
    logic [31:0]         word_s;
    logic [31:0]         addr_s;

    sm4_result_word_sel u_word_sel (
        .result_i (result_q),
        .k_i      (k_q),
        .word_o   (word_s)
    );

    // Number of words this round: four per remaining group, capped at one full round.
    always_comb begin
        rem_s    = all_group_num - end_group_num;
        nwords_s = 4'd0;
        if (all_group_num <= end_group_num) begin
            nwords_s = 4'd0;
        end else if (rem_s >= 32'(GROUPS_PER_ROUND)) begin
            nwords_s = 4'(GROUPS_PER_ROUND * WORDS_PER_GROUP);
        end else begin
            nwords_s = 4'(rem_s * 32'(WORDS_PER_GROUP));
        end
    end

    // 33-bit compare so a group index near 2^32 cannot wrap into a false "not done".
    assign final_round_s = ({1'b0, end_q} + 33'd3) >= {1'b0, all_q};

    // Since k = 4*g + w, the word address collapses to BASE + 4*end + k.
    assign addr_s = BASE_ADDR + {end_q[29:0], 2'b00} + {28'd0, k_q};
    assign last_s = (k_q == (nwords_q - 4'd1));

    // Next-state and datapath; losing h_sm4_start overrides every state.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        end_d      = end_q;
        all_d      = all_q;
        nwords_d   = nwords_q;
        k_d        = k_q;
        all_done_d = all_done_q;
        if (!h_sm4_start) begin
            state_d    = S_IDLE;
            result_d   = '0;
            k_d        = 4'd0;
            nwords_d   = 4'd0;
            all_done_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (one_round_ok) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    result_d = sm4_dout;
                    end_d    = end_group_num;
                    all_d    = all_group_num;
                    nwords_d = nwords_s;
                    k_d      = 4'd0;
                    if (nwords_s == 4'd0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_if.m_ready) begin
                        k_d = k_q + 4'd1;
                        if (last_s) begin
                            state_d = S_ACK;
                        end else begin
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_SEND;
                    end
                end
                S_ACK: begin
                    if (final_round_s) begin
                        all_done_d = 1'b1;
                    end else begin
                        all_done_d = all_done_q;
                    end
                    state_d = S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!one_round_ok) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_LOW;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            end_q      <= 32'd0;
            all_q      <= 32'd0;
            nwords_q   <= 4'd0;
            k_q        <= 4'd0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            end_q      <= end_d;
            all_q      <= all_d;
            nwords_q   <= nwords_d;
            k_q        <= k_d;
            all_done_q <= all_done_d;
        end
    end

    // Stream fields are forced to zero whenever no word is offered.
    assign send_s         = (state_q == S_SEND) && h_sm4_start;
    assign m_if.m_valid   = send_s;
    assign m_if.m_data    = send_s ? word_s : 32'd0;
    assign m_if.m_addr    = send_s ? addr_s : 32'd0;
    assign m_if.m_last    = send_s && last_s;
    assign out_ok         = (state_q == S_ACK) && h_sm4_start;
    assign all_done       = all_done_q;

endmodule

// File: tb/tb_sm4_result_writer.sv
// Self-checking bench for sm4_result_writer: directed rounds plus randomized rounds against a queue-free word model.
module tb_sm4_result_writer;
    import sm4_result_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         h_sm4_start;
    logic         one_round_ok;
    logic [383:0] sm4_dout;
    logic [31:0]  end_group_num;
    logic [31:0]  all_group_num;
    logic         out_ok;
    logic         all_done;

    sm4_result_writer_if m_if();

    sm4_result_writer #(.BASE_ADDR(BASE), .GROUPS_PER_ROUND(3)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_sm4_start   (h_sm4_start),
        .one_round_ok  (one_round_ok),
        .sm4_dout      (sm4_dout),
        .end_group_num (end_group_num),
        .all_group_num (all_group_num),
        .out_ok        (out_ok),
        .m_if          (m_if.master),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [383:0] d, input int k);
        logic [127:0] grp;
        logic [31:0]  w;
        grp = d[128*(k/4) +: 128];
        w   = 32'(grp >> (32*(3 - (k % 4))));
`ifdef SM4_RESULT_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    function automatic int model_ngroups(input logic [31:0] e, input logic [31:0] a);
        longint diff;
        diff = longint'(a) - longint'(e);
        if (diff <= 0) return 0;
        else if (diff > 3) return 3;
        else return int'(diff);
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_round(input logic [383:0] d, input logic [31:0] e, input logic [31:0] a,
                            input int ready_mode, input int hold, input string tag);
        int nw, sent, cyc, ok_cnt, ok_cyc, first_v;
        logic [31:0] pd, pa;
        logic pl, pstall;
        logic [31:0] exp_addr;
        nw = 4 * model_ngroups(e, a);
        @(negedge clk);
        sm4_dout = d; end_group_num = e; all_group_num = a;
        one_round_ok = 1'b1; m_if.m_ready = 1'b0;
        sent = 0; cyc = 0; ok_cnt = 0; ok_cyc = -1; first_v = -1; pstall = 1'b0;
        pd = 32'd0; pa = 32'd0; pl = 1'b0;
        while (ok_cnt == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       m_if.m_ready = 1'b1;
                1:       m_if.m_ready = cyc[0];
                default: m_if.m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_if.m_valid) begin
                if (first_v < 0) first_v = cyc;
                chk({tag, "_in_range"}, 32'(sent < nw), 32'd1);
                if (sent < nw) begin
                    exp_addr = BASE + 32'd4 * (e + 32'(sent / 4)) + 32'(sent % 4);
                    chk({tag, "_data"}, m_if.m_data, model_word(d, sent));
                    chk({tag, "_addr"}, m_if.m_addr, exp_addr);
                    chk({tag, "_last"}, 32'(m_if.m_last), 32'(sent == nw - 1));
                end
                if (pstall) begin
                    chk({tag, "_stall_data"}, m_if.m_data, pd);
                    chk({tag, "_stall_addr"}, m_if.m_addr, pa);
                    chk({tag, "_stall_last"}, 32'(m_if.m_last), 32'(pl));
                end
                pd = m_if.m_data; pa = m_if.m_addr; pl = m_if.m_last;
                pstall = !m_if.m_ready;
                if (m_if.m_ready) sent++;
            end else begin
                pstall = 1'b0;
            end
            if (out_ok) begin
                ok_cnt++;
                ok_cyc = cyc;
            end
        end
        chk({tag, "_ack_seen"}, 32'(ok_cnt), 32'd1);
        chk({tag, "_words"}, 32'(sent), 32'(nw));
        chk({tag, "_first_valid"}, 32'(first_v), (nw > 0) ? 32'd2 : 32'hFFFF_FFFF);
        if (ready_mode == 0) chk({tag, "_ack_cycle"}, 32'(ok_cyc), 32'(2 + nw));
        if (longint'(e) + 3 >= longint'(a)) done_model = 1'b1;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_all_done"}, 32'(all_done), 32'(done_model));
            chk({tag, "_hold_valid"}, 32'(m_if.m_valid), 32'd0);
            chk({tag, "_hold_ack"}, 32'(out_ok), 32'd0);
        end
        one_round_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_post_ack"}, 32'(out_ok), 32'd0);
        @(negedge clk);
        chk({tag, "_done_after"}, 32'(all_done), 32'(done_model));
        chk({tag, "_idle_valid"}, 32'(m_if.m_valid), 32'd0);
    endtask

    task automatic do_abort(input bit use_reset, input string tag);
        int sent, cyc;
        @(negedge clk);
        sm4_dout = rand384(); end_group_num = 32'd0; all_group_num = 32'd9;
        one_round_ok = 1'b1; m_if.m_ready = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m_if.m_valid) sent++;
        end
        chk({tag, "_reached5"}, 32'(sent), 32'd5);
        @(negedge clk);
        m_if.m_ready = 1'b0;
        one_round_ok = 1'b0;
        if (use_reset) rst_n = 1'b0;
        else h_sm4_start = 1'b0;
        @(negedge clk);
        done_model = 1'b0;
        chk({tag, "_valid"}, 32'(m_if.m_valid), 32'd0);
        chk({tag, "_ack"}, 32'(out_ok), 32'd0);
        chk({tag, "_all_done"}, 32'(all_done), 32'd0);
        chk({tag, "_state"}, 32'(u_dut.state_q), 32'(S_IDLE));
        rst_n = 1'b1;
        h_sm4_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_quiet_valid"}, 32'(m_if.m_valid), 32'd0);
            chk({tag, "_quiet_ack"}, 32'(out_ok), 32'd0);
        end
    endtask

    initial begin
        logic [383:0] pat;
        logic [31:0]  e, a;
        rst_n = 1'b0; h_sm4_start = 1'b0; one_round_ok = 1'b0;
        sm4_dout = '0; end_group_num = 32'd0; all_group_num = 32'd0;
        m_if.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_ack", 32'(out_ok), 32'd0);
        chk("rst_all_done", 32'(all_done), 32'd0);
        chk("rst_data", m_if.m_data, 32'd0);
        chk("rst_addr", m_if.m_addr, 32'd0);
        chk("rst_last", 32'(m_if.m_last), 32'd0);
        rst_n = 1'b1;
        h_sm4_start = 1'b1;

        for (int i = 0; i < 12; i++) pat[32*i +: 32] = 32'(i);
        do_round(pat, 32'd0, 32'd9, 0, 0, "full");
        do_round(pat, 32'd0, 32'd9, 1, 0, "bp");
        do_round(rand384(), 32'd6, 32'd8, 0, 0, "tail");
        do_round(rand384(), 32'd9, 32'd9, 0, 0, "zero");
        do_round(rand384(), 32'd3, 32'd9, 0, 20, "held");
        do_round(rand384(), 32'd6, 32'd10, 2, 0, "rearm");
        do_abort(1'b0, "abort_start");
        do_round(rand384(), 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 0, "wrap");
        do_abort(1'b1, "abort_rst");
        for (int r = 0; r < 16; r++) begin
            e = 32'($urandom_range(0, 40));
            a = 32'($urandom_range(0, 48));
            do_round(rand384(), e, a, 2, int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
